proj1_cpu: RTL and testbench

PROJ1_CPU -- requirements
Module: proj1_cpu

---
 rtl/proj1_pkg.sv | 80 ++++++++
 rtl/proj1_regfile.sv | 31 +++
 rtl/proj1_cpu.sv | 90 +++++++++
 tb/tb_proj1_cpu.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proj1_pkg.sv
// Shared opcode, funct and ALU-control definitions for the proj1 single-cycle MIPS core.
// The decode helper honours the PROJ1_JUMP_EN build macro for the j instruction.
package proj1_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    reg_dst_rd;
        logic    alu_src_imm;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    jump;
        alu_op_t alu_op;
    } ctrl_t;

    // Anything not recognised falls out as an all-zero control word, i.e. a NOP.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        c.alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                c.reg_write  = 1'b1;
                c.reg_dst_rd = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_op = ALU_ADD;
                    FN_SUB:  c.alu_op = ALU_SUB;
                    FN_AND:  c.alu_op = ALU_AND;
                    FN_OR:   c.alu_op = ALU_OR;
                    FN_SLT:  c.alu_op = ALU_SLT;
                    default: c.reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                c.reg_write   = 1'b1;
                c.alu_src_imm = 1'b1;
            end
            OP_LW: begin
                c.reg_write   = 1'b1;
                c.alu_src_imm = 1'b1;
                c.mem_read    = 1'b1;
            end
            OP_SW: begin
                c.alu_src_imm = 1'b1;
                c.mem_write   = 1'b1;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALU_SUB;
            end
`ifdef PROJ1_JUMP_EN
            OP_J: c.jump = 1'b1;
`endif
            default: c = c;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/proj1_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write port.
// Register 0 reads as zero and ignores writes; all entries clear on reset.
module proj1_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // Reads see the pre-edge value, so a same-cycle read of the target returns old data.
    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/proj1_cpu.sv
// Single-cycle MIPS-I subset core: decode, ALU and PC logic around proj1_regfile.
// Define PROJ1_JUMP_EN to decode j; otherwise opcode 0x02 behaves as a NOP.
module proj1_cpu
    import proj1_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] inst_addr,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] data_addr,
    output logic [XLEN-1:0] data_in,
    output logic            mem_read,
    output logic            mem_write,
    input  logic [XLEN-1:0] data_out
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_y;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      wb_addr;
    ctrl_t           ctrl;

    assign ctrl     = decode(instr[31:26], instr[5:0]);
    assign imm_sext = {{(XLEN-16){instr[15]}}, instr[15:0]};

    proj1_regfile #(.XLEN(XLEN)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (instr[25:21]),
        .ra2   (instr[20:16]),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (ctrl.reg_write & reset),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    assign alu_b = ctrl.alu_src_imm ? imm_sext : rt_val;

    always_comb begin
        alu_y = '0;
        case (ctrl.alu_op)
            ALU_ADD: alu_y = rs_val + alu_b;
            ALU_SUB: alu_y = rs_val - alu_b;
            ALU_AND: alu_y = rs_val & alu_b;
            ALU_OR:  alu_y = rs_val | alu_b;
            ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(rs_val) < $signed(alu_b))};
            default: alu_y = '0;
        endcase
    end

    assign wb_addr = ctrl.reg_dst_rd ? instr[15:11] : instr[20:16];
    assign wb_data = ctrl.mem_read ? data_out : alu_y;

    assign pc_plus4      = pc + XLEN'(4);
    assign branch_target = pc_plus4 + {imm_sext[XLEN-3:0], 2'b00};
    assign jump_target   = {pc_plus4[XLEN-1:XLEN-4], instr[25:0], 2'b00};

    always_comb begin
        pc_next = pc_plus4;
        if (ctrl.jump)
            pc_next = jump_target;
        else if (ctrl.branch && (rs_val == rt_val))
            pc_next = branch_target;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= RESET_PC;
        else        pc <= pc_next;
    end

    assign inst_addr = pc;
    assign data_addr = alu_y;
    assign data_in   = rt_val;
    // Memory strobes are suppressed for as long as reset is held low.
    assign mem_read  = ctrl.mem_read & reset;
    assign mem_write = ctrl.mem_write & reset;

endmodule

// File: tb/tb_proj1_cpu.sv
// Self-checking bench for proj1_cpu: directed programs plus random instruction streams
// checked against an instruction-level model of the architectural state.
module tb_proj1_cpu;

    logic        clk;
    logic        reset;
    logic [31:0] inst_addr;
    logic [31:0] instr;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;

    int total;
    int bad;

    logic [31:0] m_pc;
    logic [31:0] m_regs [32];
    logic [31:0] m_mem  [64];
    logic [31:0] env_mem [64];

    proj1_cpu #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .inst_addr (inst_addr),
        .instr     (instr),
        .data_addr (data_addr),
        .data_in   (data_in),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb data_out = env_mem[data_addr[7:2]];

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    endtask

    // Called at a falling edge: presents one instruction, checks outputs, retires it.
    task automatic drive_instr(input logic [31:0] ins);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs, rt, rd, wdst;
        logic [31:0] simm, a, b, nxt, wval, addr, w_a, w_d;
        logic        wr, e_mr, e_mw, w_mw;
        op = ins[31:26]; fn = ins[5:0];
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        simm = {{16{ins[15]}}, ins[15:0]};
        a = m_regs[rs]; b = m_regs[rt];
        addr = a + simm;
        nxt = m_pc + 32'd4;
        wr = 1'b0; wdst = rt; wval = 32'h0; e_mr = 1'b0; e_mw = 1'b0;
        case (op)
            6'h00: begin
                wdst = rd; wr = 1'b1;
                case (fn)
                    6'h20: wval = a + b;
                    6'h22: wval = a - b;
                    6'h24: wval = a & b;
                    6'h25: wval = a | b;
                    6'h2A: wval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 1'b0;
                endcase
            end
            6'h08: begin wr = 1'b1; wval = addr; end
            6'h23: begin wr = 1'b1; e_mr = 1'b1; wval = m_mem[addr[7:2]]; end
            6'h2B: e_mw = 1'b1;
            6'h04: if (a == b) nxt = m_pc + 32'd4 + simm * 32'd4;
`ifdef PROJ1_JUMP_EN
            6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
`endif
            default: ;
        endcase

        instr = ins;
        #1;
        total++;
        if (inst_addr !== m_pc) begin
            bad++; $display("FAIL pc: ins=%h got=%h exp=%h", ins, inst_addr, m_pc);
        end
        total++;
        if (mem_read !== e_mr || mem_write !== e_mw) begin
            bad++; $display("FAIL mem_ctl: ins=%h got rd=%b wr=%b exp rd=%b wr=%b",
                            ins, mem_read, mem_write, e_mr, e_mw);
        end
        total++;
        if (data_in !== b) begin
            bad++; $display("FAIL data_in: ins=%h got=%h exp=%h", ins, data_in, b);
        end
        if (e_mr || e_mw) begin
            total++;
            if (data_addr !== addr) begin
                bad++; $display("FAIL data_addr: ins=%h got=%h exp=%h", ins, data_addr, addr);
            end
        end
        w_mw = mem_write; w_a = data_addr; w_d = data_in;
        @(posedge clk);
        if (w_mw) env_mem[w_a[7:2]] = w_d;
        if (wr && wdst != 5'd0) m_regs[wdst] = wval;
        if (e_mw) m_mem[addr[7:2]] = b;
        m_pc = nxt;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        instr = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Reads every register out through the store-data path.
    task automatic test_reg_dump();
        for (int r = 0; r < 32; r++) drive_instr(enc_i(6'h2B, 5'd0, 5'(r), 16'(r * 4)));
    endtask

    task automatic test_reset();
        reset = 1'b0;
        instr = enc_i(6'h2B, 5'd0, 5'd1, 16'h0008);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (inst_addr !== 32'h0 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: got pc=%h wr=%b rd=%b exp pc=0 wr=0 rd=0",
                            inst_addr, mem_write, mem_read);
        end
        instr = enc_i(6'h23, 5'd0, 5'd1, 16'h0008);
        #1;
        total++;
        if (mem_read !== 1'b0) begin
            bad++; $display("FAIL reset_mem_read: got=%b exp=0", mem_read);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        test_reg_dump();
    endtask

    task automatic test_arith_mem_branch();
        apply_reset();
        drive_instr(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        drive_instr(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        drive_instr(enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        drive_instr(enc_r(5'd2, 5'd1, 5'd4, 6'h2A));
        drive_instr(enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF));
        total++;
        if (inst_addr !== 32'h10) begin
            bad++; $display("FAIL beq_taken: got=%h exp=%h", inst_addr, 32'h10);
        end
        drive_instr(enc_i(6'h04, 5'd1, 5'd2, 16'd4));
        total++;
        if (inst_addr !== 32'h14) begin
            bad++; $display("FAIL beq_not_taken: got=%h exp=%h", inst_addr, 32'h14);
        end
        drive_instr(enc_i(6'h2B, 5'd0, 5'd1, 16'd8));
        drive_instr(enc_i(6'h23, 5'd0, 5'd5, 16'd8));
        drive_instr(enc_i(6'h08, 5'd0, 5'd0, 16'd7));
        drive_instr({6'h3F, 26'h0});
        total++;
        if (inst_addr !== 32'h24) begin
            bad++; $display("FAIL illegal_nop_pc: got=%h exp=%h", inst_addr, 32'h24);
        end
        drive_instr(enc_i(6'h2B, 5'd0, 5'd3, 16'h0040));
        drive_instr(enc_i(6'h2B, 5'd0, 5'd4, 16'h0044));
        drive_instr(enc_i(6'h2B, 5'd0, 5'd5, 16'h0048));
        drive_instr(enc_i(6'h2B, 5'd0, 5'd0, 16'h004C));
    endtask

    task automatic test_jump();
        logic [31:0] exp_j;
`ifdef PROJ1_JUMP_EN
        exp_j = 32'h100;
`else
        exp_j = 32'h4;
`endif
        apply_reset();
        drive_instr(enc_j(26'h40));
        total++;
        if (inst_addr !== exp_j) begin
            bad++; $display("FAIL jump_target: got=%h exp=%h", inst_addr, exp_j);
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [5:0]  fns [5];
        logic [5:0]  ops [6];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        ops = '{6'h01, 6'h0F, 6'h3F, 6'h10, 6'h22, 6'h05};
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: ins = enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                     5'($urandom_range(0, 7)),
                                     ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                                                 : fns[$urandom_range(0, 4)]);
                3: ins = enc_i(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                               16'($urandom));
                4: ins = enc_i(6'h23, ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)), {8'h0, 6'($urandom), 2'b00});
                5: ins = enc_i(6'h2B, ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 7)),
                               5'($urandom_range(0, 7)), {8'h0, 6'($urandom), 2'b00});
                6: ins = enc_i(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                               16'($signed($urandom_range(0, 16)) - 8));
                7: ins = enc_j(26'($urandom));
                8: ins = {ops[$urandom_range(0, 5)], 26'($urandom)};
                default: ins = $urandom;
            endcase
            drive_instr(ins);
        end
        test_reg_dump();
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int n = 0; n < 6; n++)
            drive_instr(enc_i(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(1, 7)),
                              16'($urandom)));
        instr = enc_i(6'h2B, 5'd0, 5'd1, 16'h0010);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (inst_addr !== 32'h0 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
            bad++; $display("FAIL async_reset: got pc=%h wr=%b rd=%b exp pc=0 wr=0 rd=0",
                            inst_addr, mem_write, mem_read);
        end
        @(negedge clk);
        total++;
        if (inst_addr !== 32'h0) begin
            bad++; $display("FAIL async_reset_hold: got=%h exp=0", inst_addr);
        end
        reset = 1'b1;
        model_reset();
        test_reg_dump();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drive_instr(enc_i(6'h08, 5'd0, 5'd6, 16'h1234));
        drive_instr(enc_i(6'h2B, 5'd0, 5'd6, 16'h0020));
        drive_instr(enc_i(6'h23, 5'd0, 5'd7, 16'h0020));
        drive_instr(enc_r(5'd7, 5'd7, 5'd7, 6'h20));
        drive_instr(enc_r(5'd7, 5'd6, 5'd8, 6'h22));
        drive_instr(enc_i(6'h2B, 5'd0, 5'd7, 16'h0024));
        drive_instr(enc_i(6'h2B, 5'd0, 5'd8, 16'h0028));
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        instr = 32'h0;
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 32'h0;
            m_mem[i] = 32'h0;
        end
        model_reset();
        @(negedge clk);
        test_reset();
        test_arith_mem_branch();
        test_jump();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
